// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix product sequencer.
// Word width, sequencer state encoding, quiet-NaN filler, index width helper.
package mm_pkg;

  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_RES = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/matrix_slice_mux.sv
// Selects row i of A and column j of B from flat row-major matrices.
// Purely combinational; the sequencer registers the result.
module matrix_slice_mux
  import mm_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [WORD_WIDTH*N*N-1:0] a_m,
  input  logic [WORD_WIDTH*N*N-1:0] b_m,
  input  logic [IW-1:0]             i,
  input  logic [IW-1:0]             j,
  output logic [WORD_WIDTH*N-1:0]   row,
  output logic [WORD_WIDTH*N-1:0]   column
);

  always_comb begin
    row    = a_m[WORD_WIDTH*N*int'(i) +: WORD_WIDTH*N];
    column = '0;
    for (int k = 0; k < N; k++) begin
      column[WORD_WIDTH*k +: WORD_WIDTH] =
        b_m[WORD_WIDTH*(k*N + int'(j)) +: WORD_WIDTH];
    end
  end

endmodule

// File: rtl/matrix_product_sequencer.sv
// Issues row/column pairs to an inner-product engine and assembles C = A x B.
// MPS_WATCHDOG_EN adds a per-state timeout that fills C[i][j] with NaN.
module matrix_product_sequencer
  import mm_pkg::*;
#(
  parameter int number_of_elements = 4,
  parameter int timeout_cycles     = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic [WORD_WIDTH*number_of_elements*number_of_elements-1:0] a,
  input  logic [WORD_WIDTH*number_of_elements*number_of_elements-1:0] b,
  input  logic ab_i_stb,
  output logic ab_i_ack,
  output logic [WORD_WIDTH*number_of_elements-1:0] ip_row,
  output logic [WORD_WIDTH*number_of_elements-1:0] ip_column,
  output logic ip_row_stb,
  output logic ip_column_stb,
  output logic ip_out_ack,
  input  logic ip_row_ack,
  input  logic ip_column_ack,
  input  logic [WORD_WIDTH-1:0] ip_out,
  input  logic ip_out_stb,
  output logic [WORD_WIDTH*number_of_elements*number_of_elements-1:0] c,
`ifdef MPS_WATCHDOG_EN
  output logic err,
`endif
  output logic c_o_stb,
  input  logic c_o_ack
);

  localparam int N  = number_of_elements;
  localparam int IW = clog2(N);
  localparam int MW = WORD_WIDTH*N*N;
  localparam int VW = WORD_WIDTH*N;
  localparam logic [IW-1:0] LAST = IW'(N-1);

  state_t state, state_d;
  logic [MW-1:0] a_q, b_q, a_d, b_d;
  logic [IW-1:0] i_q, j_q, i_d, j_d;
  logic [VW-1:0] row_d, col_d;
  logic take, res, drain_ok, last, advance, wr, tmo;
  logic [WORD_WIDTH-1:0] wdata;

`ifdef MPS_WATCHDOG_EN
  localparam int CW = clog2(timeout_cycles) + 1;
  logic [CW-1:0] cnt;

  assign tmo = (state == ISSUE || state == WAIT_RES || state == DRAIN)
            && cnt == CW'(timeout_cycles - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state_d != state) ? '0 : cnt + 1'b1;
      if (take)     err <= 1'b0;
      else if (tmo) err <= 1'b1;
    end
  end
`else
  assign tmo = (timeout_cycles < 0);
`endif

  assign take     = state == IDLE && ab_i_stb;
  assign res      = state == WAIT_RES && ip_out_stb;
  assign drain_ok = state == DRAIN && !ip_out_stb && !ip_row_ack;
  assign last     = i_q == LAST && j_q == LAST;
  assign advance  = state == DRAIN && (drain_ok || tmo) && !last;
  assign wr       = res || tmo;
  assign wdata    = res ? ip_out : QNAN;

  assign ip_row_stb    = state == ISSUE;
  assign ip_column_stb = state == ISSUE;
  assign ip_out_ack    = state == ISSUE || state == WAIT_RES;
  assign c_o_stb       = state == DONE;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (ab_i_stb) state_d = ISSUE;
      ISSUE: begin
        if (ip_row_ack && ip_column_ack) state_d = WAIT_RES;
        if (tmo) state_d = DRAIN;
      end
      WAIT_RES: if (ip_out_stb || tmo) state_d = DRAIN;
      DRAIN:    if (drain_ok || tmo) state_d = last ? DONE : ISSUE;
      DONE:     if (c_o_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d = take ? a : a_q;
    b_d = take ? b : b_q;
    i_d = i_q;
    j_d = j_q;
    if (take) begin
      i_d = '0;
      j_d = '0;
    end else if (advance) begin
      if (j_q == LAST) begin
        j_d = '0;
        i_d = i_q + 1'b1;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  // Slices follow the next-cycle operands so they are valid on ISSUE entry.
  matrix_slice_mux #(.N(N), .IW(IW)) u_mux (
    .a_m    (a_d),
    .b_m    (b_d),
    .i      (i_d),
    .j      (j_d),
    .row    (row_d),
    .column (col_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      ip_row    <= '0;
      ip_column <= '0;
      ab_i_ack  <= 1'b0;
      c         <= '0;
    end else begin
      state     <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      i_q       <= i_d;
      j_q       <= j_d;
      ip_row    <= row_d;
      ip_column <= col_d;
      ab_i_ack  <= take;
      if (take) c <= '0;
      else if (wr)
        c[WORD_WIDTH*(int'(i_q)*N + int'(j_q)) +: WORD_WIDTH] <= wdata;
    end
  end

endmodule
